// File: rtl/glyph_ram_loader_pkg.sv
// Shared constants for the reloadable glyph RAM: default geometry, loader FSM
// encodings and character-set base rows used by both the loader host and the renderer.
package glyph_ram_loader_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ALO  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [9:0] CHAR_ASCII_BASE = 10'd0;
    localparam logic [9:0] CHAR_BOX_BASE   = 10'd512;
    localparam logic [9:0] CHAR_USER_BASE  = 10'd768;

    // An ADDR_HI byte is legal only when every bit above the used address bits is zero.
    function automatic logic hi_bits_ok(input logic [7:0] b, input int hi_w);
        return (b >> hi_w) == 8'd0;
    endfunction

endpackage

// File: rtl/glyph_dpram.sv
// Glyph row storage: one write port, one registered read port sharing a clock.
// A read and a write to the same row in one cycle return the old row.
module glyph_dpram
    import glyph_ram_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_adr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_adr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Write and registered read; the read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_adr] <= wr_data;
        end
        rd_data_q <= mem[rd_adr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/glyph_ram_loader.sv
// Glyph RAM responder: registered row reads for the renderer plus a byte-serial
// loader (ADDR_HI, ADDR_LO, rows MSB byte first) that rewrites rows at run time.
module glyph_ram_loader
    import glyph_ram_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rom_adr,
    output logic [DATA_W-1:0] rom_data,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] wr_count
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int HI_W  = ADDR_W - 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [1:0]        state_q, state_d;
    logic              ld_ready_q, ld_ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] wr_count_q, wr_count_d;
    logic [ADDR_W-1:0] wr_adr_q, wr_adr_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0] row_buf_q, row_buf_d;
    logic              rd_en_q;

    logic              xfer_s;
    logic              we_s;
    logic [DATA_W-1:0] row_s;
    logic [DATA_W-1:0] ram_rd_s;

    assign xfer_s = ld_valid & ld_ready_q;

    // Loader FSM: address capture, byte assembly and row commit.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        wr_count_d = wr_count_q;
        wr_adr_d   = wr_adr_q;
        byte_idx_d = byte_idx_q;
        row_buf_d  = row_buf_q;
        we_s       = 1'b0;
        row_s      = (row_buf_q << 8) | DATA_W'(ld_byte);

        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    if (!hi_bits_ok(ld_byte, HI_W) || ld_last) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d      = 1'b0;
                        wr_count_d = {ADDR_W{1'b0}};
                        wr_adr_d   = {ld_byte[HI_W-1:0], wr_adr_q[7:0]};
                        state_d    = ST_ALO;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALO: begin
                if (xfer_s) begin
                    if (ld_last) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        wr_adr_d   = {wr_adr_q[ADDR_W-1:8], ld_byte};
                        byte_idx_d = {IDX_W{1'b0}};
                        row_buf_d  = {DATA_W{1'b0}};
                        state_d    = ST_DATA;
                    end
                end else begin
                    state_d = ST_ALO;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    row_buf_d = row_s;
                    if (byte_idx_q == LAST_IDX) begin
                        // Full row: commit in this same clock; a trailing last simply ends the frame.
                        we_s       = 1'b1;
                        wr_adr_d   = wr_adr_q + ADDR_W'(1);
                        wr_count_d = wr_count_q + ADDR_W'(1);
                        byte_idx_d = {IDX_W{1'b0}};
                        state_d    = ld_last ? ST_DONE : ST_DATA;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                        if (ld_last) begin
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ld_ready_d = (state_d != ST_DONE);
    assign busy_d     = (state_d != ST_IDLE);

    // Loader state registers; a reset drops any partially assembled row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_count_q <= {ADDR_W{1'b0}};
            wr_adr_q   <= {ADDR_W{1'b0}};
            byte_idx_q <= {IDX_W{1'b0}};
            row_buf_q  <= {DATA_W{1'b0}};
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_ready_q <= ld_ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
            wr_adr_q   <= wr_adr_d;
            byte_idx_q <= byte_idx_d;
            row_buf_q  <= row_buf_d;
            rd_en_q    <= 1'b1;
        end
    end

    glyph_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we      (we_s),
        .wr_adr  (wr_adr_q),
        .wr_data (row_s),
        .rd_adr  (rom_adr),
        .rd_data (ram_rd_s)
    );

    // The RAM read register has no reset, so its output is masked until the first clock out of reset.
    assign rom_data = rd_en_q ? ram_rd_s : {DATA_W{1'b0}};
    assign ld_ready = ld_ready_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_glyph_ram_loader.sv
// Self-checking bench for glyph_ram_loader: frame-level reference model of the
// glyph memory, err and wr_count, checked every idle cycle, plus directed literal checks.
module tb_glyph_ram_loader;

    logic        clk;
    logic        rst;
    logic [9:0]  rom_adr;
    logic [31:0] rom_data;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        busy;
    logic        err;
    logic [9:0]  wr_count;

    glyph_ram_loader dut (
        .clk      (clk),
        .rst      (rst),
        .rom_adr  (rom_adr),
        .rom_data (rom_data),
        .ld_valid (ld_valid),
        .ld_byte  (ld_byte),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .busy     (busy),
        .err      (err),
        .wr_count (wr_count)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_mem [1024];
    logic        exp_err = 1'b0;
    logic [9:0]  exp_wc  = 10'd0;
    logic [7:0]  fb [$];
    bit          chk_en   = 1'b0;
    bit          rand_adr = 1'b0;
    logic [9:0]  adr_prev;
    logic [31:0] saved;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) adr_prev <= rom_adr;

    // Every idle cycle: read port against the model, control outputs against idle values.
    always @(negedge clk) begin
        if (chk_en && rst) begin
            chk("rd_data", rom_data, exp_mem[adr_prev]);
            chk("idle_ready", {31'd0, ld_ready}, 32'd1);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_err", {31'd0, err}, {31'd0, exp_err});
            chk("idle_wc", {22'd0, wr_count}, {22'd0, exp_wc});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_adr) rom_adr = 10'($urandom_range(0, 1023));
        end
    end

    // Frame-level effect on memory, err and wr_count, from the frame bytes alone.
    task automatic apply_model();
        int n = fb.size();
        int nd;
        int rows;
        logic [9:0] base;
        if (fb[0][7:2] != 6'd0 || n == 1) begin
            exp_err = 1'b1;
            return;
        end
        exp_err = 1'b0;
        exp_wc  = 10'd0;
        if (n == 2) begin
            exp_err = 1'b1;
            return;
        end
        nd   = n - 2;
        rows = nd / 4;
        base = {fb[0][1:0], fb[1]};
        for (int r = 0; r < rows; r++)
            exp_mem[10'(base + r)] = {fb[2+4*r], fb[3+4*r], fb[4+4*r], fb[5+4*r]};
        exp_wc  = 10'(rows);
        exp_err = (nd % 4) != 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
                ld_byte = 8'($urandom);
                ld_last = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        while (!ld_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("ready_timeout", {31'd0, ld_ready}, 32'd1);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic send_bytes();
        chk_en = 1'b0;
        for (int i = 0; i < fb.size(); i++) send_byte(fb[i], i == fb.size() - 1);
    endtask

    task automatic finish_frame();
        chk("done_ready", {31'd0, ld_ready}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd1);
        apply_model();
        @(posedge clk);
        #1;
        chk("post_ready", {31'd0, ld_ready}, 32'd1);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_err", {31'd0, err}, {31'd0, exp_err});
        chk("post_wc", {22'd0, wr_count}, {22'd0, exp_wc});
        @(posedge clk);
        #1;
        chk_en = 1'b1;
    endtask

    task automatic read_row(input logic [9:0] a, input string nm, input logic [31:0] exp);
        rom_adr = a;
        @(posedge clk);
        #1;
        chk(nm, rom_data, exp);
    endtask

    initial begin
        rst = 1'b0; ld_valid = 1'b0; ld_byte = 8'd0; ld_last = 1'b0; rom_adr = 10'd5;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_data", rom_data, 32'd0);
        chk("rst_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        chk("rel_ready_still_low", {31'd0, ld_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rel_ready", {31'd0, ld_ready}, 32'd1);
        chk("rel_err", {31'd0, err}, 32'd0);
        chk("rel_wc", {22'd0, wr_count}, 32'd0);

        // Fill the whole memory so the model knows every row
        fb = {};
        fb.push_back(8'h00); fb.push_back(8'h00);
        for (int i = 0; i < 4096; i++) fb.push_back(8'($urandom));
        send_bytes(); finish_frame();

        // Single row at 16
        fb = '{8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_bytes(); finish_frame();
        chk("model_row16", exp_mem[16], 32'hAABBCCDD);
        chk_en = 1'b0;
        read_row(10'd16, "row16", 32'hAABBCCDD);
        chk("wc_one", {22'd0, wr_count}, 32'd1);
        chk("err_zero", {31'd0, err}, 32'd0);

        // Address wrap from 1023 to 0
        fb = '{8'h03, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_bytes(); finish_frame();
        chk_en = 1'b0;
        read_row(10'd1023, "row1023", 32'h11223344);
        read_row(10'd0, "row0_wrap", 32'h55667788);
        chk("wc_two", {22'd0, wr_count}, 32'd2);

        // Partial trailing row is discarded with an error
        saved = exp_mem[33];
        fb = '{8'h00, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_bytes(); finish_frame();
        chk_en = 1'b0;
        chk("partial_err", {31'd0, err}, 32'd1);
        read_row(10'd32, "row32", 32'h01020304);
        read_row(10'd33, "row33_kept", saved);
        fb = '{8'h00, 8'h21, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        send_bytes(); finish_frame();
        chk("err_cleared", {31'd0, err}, 32'd0);

        // Illegal ADDR_HI
        fb = '{8'h84};
        send_bytes(); finish_frame();
        chk("bad_hi_err", {31'd0, err}, 32'd1);
        chk("bad_hi_wc", {22'd0, wr_count}, 32'd1);

        // Same-cycle read and write of row 40
        fb = '{8'h00, 8'h28, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
        send_bytes(); finish_frame();
        chk_en = 1'b0;
        rom_adr = 10'd40;
        fb = '{8'h00, 8'h28, 8'h12, 8'h34, 8'h56, 8'h78};
        send_bytes();
        chk("rbw_old", rom_data, 32'h0BADF00D);
        finish_frame();
        chk("rbw_new", rom_data, 32'h12345678);

        // Reset in the middle of a frame
        chk_en = 1'b0;
        fb = '{8'h00, 8'h30, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
        for (int i = 0; i < fb.size(); i++) send_byte(fb[i], 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_rom", rom_data, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        exp_mem[48] = 32'hA1A2A3A4;
        exp_err = 1'b0;
        exp_wc  = 10'd0;
        @(posedge clk);
        #1;
        read_row(10'd48, "row48_kept", 32'hA1A2A3A4);
        read_row(10'd49, "row49_untouched", exp_mem[49]);
        chk("mid_rst_wc", {22'd0, wr_count}, 32'd0);
        chk_en = 1'b1;

        // Random frames with the model checking every idle cycle
        rand_adr = 1'b1;
        for (int f = 0; f < 60; f++) begin
            int t = $urandom_range(0, 9);
            fb = {};
            if (t == 0) begin
                fb.push_back({6'($urandom_range(1, 63)), 2'($urandom)});
            end else if (t == 1) begin
                fb.push_back({6'd0, 2'($urandom)});
            end else begin
                fb.push_back({6'd0, 2'($urandom)});
                fb.push_back(8'($urandom));
                if (t != 2) begin
                    int nd = $urandom_range(1, 18);
                    for (int i = 0; i < nd; i++) fb.push_back(8'($urandom));
                end
            end
            send_bytes();
            finish_frame();
            repeat ($urandom_range(3, 6)) @(posedge clk);
            #1;
        end
        chk_en = 1'b0;
        rand_adr = 1'b0;
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
